// File: rtl/wb_tracker_if.sv
// Trace element types and the bundled EX-in / WB-out signal group for wb_tracker.
// The package sits ahead of the interface so both the tracker and its users see one definition.
package wb_tracker_pkg;

  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
  } time_pair_t;

  typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
    time_pair_t  mem_access_res;
  } wb_data_t;

  typedef struct packed {
    logic [31:0] instruction;
    wb_data_t    wb_data;
  } trace_output;

endpackage

interface wb_tracker_if;
  import wb_tracker_pkg::*;

  logic [31:0] counter;
  logic        ex_data_ready;
  trace_output ex_data_in;
  logic        ex_mem_access;
  logic        wb_ready;
  logic        data_rvalid_i;
  trace_output wb_data_o;
  logic        wb_data_ready;
  logic        overflow;
  logic        trace_error;

  modport master (
    output counter, ex_data_ready, ex_data_in, ex_mem_access, wb_ready, data_rvalid_i,
    input  wb_data_o, wb_data_ready, overflow, trace_error
  );

  modport slave (
    input  counter, ex_data_ready, ex_data_in, ex_mem_access, wb_ready, data_rvalid_i,
    output wb_data_o, wb_data_ready, overflow, trace_error
  );

endinterface

// File: rtl/wb_tracker.sv
// Writeback-stage trace tracker: queues EX trace elements, timestamps the writeback
// and data-memory response phases, and emits each finished element as a one-cycle pulse.
module wb_tracker #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  wb_tracker_if.slave bus
);
  import wb_tracker_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_WIDTH < 1) begin : g_bad_param
    $error("wb_tracker: DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT_RVALID, WAIT_WB} state_t;

  typedef struct packed {
    trace_output elem;
    logic        mem;
  } entry_t;

  entry_t      fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  state_t      state;
  trace_output work;
  logic [31:0] last_instr;

  logic        push, push_ok, pop, full, empty;
  entry_t      in_entry;
  trace_output load_elem;
  state_t      load_state;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
    push  = bus.ex_data_ready && (bus.ex_data_in.instruction != last_instr);
    pop   = !empty && (state == IDLE || (state == WAIT_WB && bus.wb_ready));
    // A full FIFO still accepts when the head leaves on the same edge.
    push_ok = push && (!full || pop);

    in_entry                          = '{elem: bus.ex_data_in, mem: bus.ex_mem_access};
    in_entry.elem.wb_data.time_start  = bus.counter;

    load_elem  = fifo_mem[rd_ptr].elem;
    load_state = WAIT_WB;
    if (fifo_mem[rd_ptr].mem) begin
      load_elem.wb_data.mem_access_res.time_start = bus.counter;
      load_state = WAIT_RVALID;
    end
  end

  // NOTE: storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= in_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      last_instr        <= '0;
      work              <= '0;
      bus.wb_data_o     <= '0;
      bus.wb_data_ready <= 1'b0;
      bus.overflow      <= 1'b0;
      bus.trace_error   <= 1'b0;
    end else begin
      bus.wb_data_ready <= 1'b0;

      if (push) last_instr <= bus.ex_data_in.instruction;
      if (push && !push_ok) bus.overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);

      if (bus.data_rvalid_i && state != WAIT_RVALID) bus.trace_error <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            work  <= load_elem;
            state <= load_state;
          end
        end
        WAIT_RVALID: begin
          if (bus.data_rvalid_i) begin
            work.wb_data.mem_access_res.time_end <= bus.counter;
            state <= WAIT_WB;
          end
        end
        WAIT_WB: begin
          if (bus.wb_ready) begin
            bus.wb_data_o                  <= work;
            bus.wb_data_o.wb_data.time_end <= bus.counter;
            bus.wb_data_ready              <= 1'b1;
            if (pop) begin
              work  <= load_elem;
              state <= load_state;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_tracker.sv
// Self-checking bench for wb_tracker: vector table of single elements plus hand-written
// sequences; expected elements go into a scoreboard queue and are matched on each pulse.
module tb_wb_tracker;
  import wb_tracker_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_tracker_if bus ();

  wb_tracker #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] ts;
    logic [31:0] te;
    logic [31:0] ms;
    logic [31:0] me;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        mem;
    logic [31:0] c0;
    int          rv;
    int          wr;
    logic [31:0] ts;
    logic [31:0] te;
    logic [31:0] ms;
    logic [31:0] me;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   pulse_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] in_ms(input logic [31:0] ins);
    return ~ins;
  endfunction

  function automatic logic [31:0] in_me(input logic [31:0] ins);
    return ins ^ 32'h5A5A_5A5A;
  endfunction

  // Apply one cycle of stimulus; counter is the value sampled at the coming edge.
  task automatic cyc(input logic [31:0] c, input logic exr, input logic [31:0] ins,
                     input logic mem, input logic wbr, input logic rv);
    bus.counter                                  = c;
    bus.ex_data_ready                            = exr;
    bus.ex_data_in.instruction                   = ins;
    bus.ex_data_in.wb_data.time_start            = 32'hFFFF_FFFF;
    bus.ex_data_in.wb_data.time_end              = 32'hEEEE_EEEE;
    bus.ex_data_in.wb_data.mem_access_res.time_start = in_ms(ins);
    bus.ex_data_in.wb_data.mem_access_res.time_end   = in_me(ins);
    bus.ex_mem_access                            = mem;
    bus.wb_ready                                 = wbr;
    bus.data_rvalid_i                            = rv;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t nonmem_exp(input logic [31:0] ins, input logic [31:0] ts,
                                      input logic [31:0] te);
    return '{ins, ts, te, in_ms(ins), in_me(ins)};
  endfunction

  always @(negedge clk) begin
    if (bus.wb_data_ready === 1'b1) begin
      pulse_count++;
      if (sb.size() == 0) begin
        check("unexpected_pulse_instr", bus.wb_data_o.instruction, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_instr", bus.wb_data_o.instruction, mon_e.instr);
        check("pulse_time_start", bus.wb_data_o.wb_data.time_start, mon_e.ts);
        check("pulse_time_end", bus.wb_data_o.wb_data.time_end, mon_e.te);
        check("pulse_mem_start", bus.wb_data_o.wb_data.mem_access_res.time_start, mon_e.ms);
        check("pulse_mem_end", bus.wb_data_o.wb_data.mem_access_res.time_end, mon_e.me);
      end
    end
  end

  vec_t vecs[5];
  int   base;

  initial begin
    vecs[0] = '{32'h00A0_0093, 1'b0, 32'd100, 0, 0, 32'd100, 32'd102,
                ~32'h00A0_0093, 32'h00A0_0093 ^ 32'h5A5A_5A5A};
    vecs[1] = '{32'h0000_A103, 1'b1, 32'd200, 5, 7, 32'd200, 32'd207, 32'd201, 32'd205};
    vecs[2] = '{32'h0040_2183, 1'b1, 32'd300, 2, 0, 32'd300, 32'd303, 32'd301, 32'd302};
    vecs[3] = '{32'h0080_2203, 1'b1, 32'd400, 3, 3, 32'd400, 32'd404, 32'd401, 32'd403};
    vecs[4] = '{32'h0011_0113, 1'b0, 32'd500, 0, 5, 32'd500, 32'd505,
                ~32'h0011_0113, 32'h0011_0113 ^ 32'h5A5A_5A5A};

    rst = 1'b0;
    bus.counter = '0;
    bus.ex_data_ready = 1'b0;
    bus.ex_data_in = '0;
    bus.ex_mem_access = 1'b0;
    bus.wb_ready = 1'b0;
    bus.data_rvalid_i = 1'b0;

    // Reset with random activity on the inputs.
    for (int k = 0; k < 3; k++)
      cyc($urandom, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    check("rst_wb_data_ready", 32'(bus.wb_data_ready), 32'd0);
    check("rst_wb_data_o_instr", bus.wb_data_o.instruction, 32'd0);
    check("rst_wb_data_o_tstart", bus.wb_data_o.wb_data.time_start, 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_trace_error", 32'(bus.trace_error), 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) cyc(32'(k), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("idle_no_pulse", 32'(pulse_count), 32'd0);

    // Table of single elements.
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{vecs[i].instr, vecs[i].ts, vecs[i].te, vecs[i].ms, vecs[i].me});
      for (int k = 0; k < 12; k++)
        cyc(vecs[i].c0 + 32'(k), k == 0, vecs[i].instr, vecs[i].mem, k >= vecs[i].wr,
            vecs[i].mem && k == vecs[i].rv);
      check("vec_drained", 32'(sb.size()), 32'd0);
    end
    check("vec_pulse_count", 32'(pulse_count), 32'd5);

    // Dedup: held valid on one instruction yields one element.
    base = pulse_count;
    sb.push_back(nonmem_exp(32'h0030_0313, 32'd1000, 32'd1002));
    for (int k = 0; k < 10; k++) cyc(32'd1000 + 32'(k), 1'b1, 32'h0030_0313, 1'b0, 1'b1, 1'b0);
    for (int k = 10; k < 14; k++) cyc(32'd1000 + 32'(k), 1'b0, 32'h0030_0313, 1'b0, 1'b1, 1'b0);
    check("dedup_one_pulse", 32'(pulse_count - base), 32'd1);

    // Overflow: six distinct pushes with wb stalled, five retained.
    base = pulse_count;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) sb.push_back(nonmem_exp(32'h0100_0000 + 32'(k), 32'd2000 + 32'(k),
                                         32'd2010 + 32'(k)));
      cyc(32'd2000 + 32'(k), 1'b1, 32'h0100_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    end
    for (int k = 6; k < 10; k++) cyc(32'd2000 + 32'(k), 1'b0, 32'h0100_0005, 1'b0, 1'b0, 1'b0);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    check("ovf_no_pulse_stalled", 32'(pulse_count - base), 32'd0);
    for (int k = 10; k < 18; k++) cyc(32'd2000 + 32'(k), 1'b0, 32'h0100_0005, 1'b0, 1'b1, 1'b0);
    check("ovf_five_pulses", 32'(pulse_count - base), 32'd5);

    // Back-to-back non-mem elements.
    base = pulse_count;
    for (int k = 0; k < 4; k++) begin
      sb.push_back(nonmem_exp(32'h0200_0000 + 32'(k), 32'd3000 + 32'(k), 32'd3002 + 32'(k)));
      cyc(32'd3000 + 32'(k), 1'b1, 32'h0200_0000 + 32'(k), 1'b0, 1'b1, 1'b0);
    end
    for (int k = 4; k < 10; k++) cyc(32'd3000 + 32'(k), 1'b0, 32'h0200_0003, 1'b0, 1'b1, 1'b0);
    check("b2b_four_pulses", 32'(pulse_count - base), 32'd4);
    check("pre_stray_trace_error", 32'(bus.trace_error), 32'd0);

    // Stray response in IDLE.
    base = pulse_count;
    cyc(32'd3500, 1'b0, 32'h0200_0003, 1'b0, 1'b0, 1'b1);
    cyc(32'd3501, 1'b0, 32'h0200_0003, 1'b0, 1'b0, 1'b0);
    cyc(32'd3502, 1'b0, 32'h0200_0003, 1'b0, 1'b0, 1'b0);
    check("stray_trace_error", 32'(bus.trace_error), 32'd1);
    check("stray_no_pulse", 32'(pulse_count - base), 32'd0);

    // Reset while in WAIT_RVALID with two queued elements.
    cyc(32'd4000, 1'b1, 32'h0300_0003, 1'b1, 1'b0, 1'b0);
    cyc(32'd4001, 1'b1, 32'h0300_0013, 1'b0, 1'b0, 1'b0);
    cyc(32'd4002, 1'b1, 32'h0300_0023, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(32'd4003, 1'b0, 32'h0300_0023, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    base = pulse_count;
    for (int k = 4; k < 12; k++) cyc(32'd4000 + 32'(k), 1'b0, 32'h0, 1'b0, 1'b1, k == 6);
    check("midrst_no_pulse", 32'(pulse_count - base), 32'd0);
    check("midrst_overflow_clear", 32'(bus.overflow), 32'd0);
    sb.push_back(nonmem_exp(32'h0300_0023, 32'd5000, 32'd5002));
    for (int k = 0; k < 6; k++) cyc(32'd5000 + 32'(k), k == 0, 32'h0300_0023, 1'b0, 1'b1, 1'b0);
    check("midrst_next_emits", 32'(pulse_count - base), 32'd1);

    check("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_tracker.md
# wb_tracker

Writeback-stage trace tracker, directly downstream of the EX tracker. It accepts completed EX-stage trace elements into a small FIFO. It timestamps each element's writeback phase, including the data-memory response (`data_rvalid_i`) for memory instructions. It then emits the finished element to the trace sink as a one-cycle `wb_data_ready` pulse.

## Interface
- `DEPTH`, 4 — pending-element FIFO depth; power of two, ≥2.
- `ADDR_WIDTH`, 32 — kept for parity with sibling trackers; unused internally.

Ports:
- `clk`  in  1  — sole clock; all state updates on rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `counter`  in  32 (integer)  — global cycle count; sampled for all timestamps.
- `ex_data_ready`  in  1  — EX tracker output valid (level; may stay high for many cycles).
- `ex_data_in`  in  trace_output  — element from EX tracker.
- `ex_mem_access`  in  1  — qualifies `ex_data_in`: element performed a data-memory request and expects one `data_rvalid_i`.
- `wb_ready`  in  1  — WB pipeline stage completing this cycle.
- `data_rvalid_i`  in  1  — data-memory response valid.
- `wb_data_o`  out  trace_output  — finished element.
- `wb_data_ready`  out  1  — one-cycle pulse per finished element.
- `overflow`  out  1  — sticky: element dropped because the FIFO was full.
- `trace_error`  out  1  — sticky: `data_rvalid_i` seen outside WAIT_RVALID.

`trace_output` carries `wb_data.time_start`, `wb_data.time_end`, `wb_data.mem_access_res.time_start` and `wb_data.mem_access_res.time_end` (32-bit each).

## Operation
- **Accept:**
  - Edge with `ex_data_ready`=1 and `ex_data_in.instruction` ≠ `last_instr` → push {element with `wb_data.time_start`=counter, `ex_mem_access`}, then `last_instr`←instruction.
  - A held `ex_data_ready` with the same instruction is not re-pushed.
- **Full:**
  - A push while full with no pop on the same edge → element dropped, `overflow`←1, `last_instr` still updated.
  - A push and a pop on the same edge while full → both succeed.
- **FSM (head processing), states IDLE, WAIT_RVALID, WAIT_WB:**
  - IDLE: FIFO non-empty → load head into work register and pop.
    - If the head is a mem element: `mem_access_res.time_start`←counter, go to WAIT_RVALID.
    - Otherwise go to WAIT_WB.
  - WAIT_RVALID: `data_rvalid_i`=1 → `mem_access_res.time_end`←counter, go to WAIT_WB.
  - WAIT_WB: `wb_ready`=1 → `wb_data_o`←work with `wb_data.time_end`=counter, `wb_data_ready`←1.
    - If the FIFO is non-empty on the same edge, load the next head immediately (same rules as IDLE).
    - Otherwise go to IDLE.
- **Non-mem elements:** `mem_access_res` fields are left at their incoming values; they are never written.
- **Stray `data_rvalid_i`:** in IDLE or WAIT_WB, `trace_error`←1 and the response is otherwise ignored.
- **Reset** (`rst`=0 at edge), taking priority over every other event including a mid-operation element:
  - FSM→IDLE, FIFO emptied (pointers and count 0).
  - `last_instr`←0, work register discarded.
  - `wb_data_ready`=0, `wb_data_o`='0, `overflow`=0, `trace_error`=0.

## Timing
- All outputs are registered. `wb_data_ready` is high for exactly one cycle per element; consecutive-cycle pulses are distinct elements.
- Minimum latency for a non-mem element, FIFO empty, `wb_ready` held 1:
  - push at edge E0, load at E1, emit at E2.
  - `wb_data_ready` is high in the cycle after E2.
- Mem element: emits at the first `wb_ready` edge strictly after the `data_rvalid_i` edge.
  - `data_rvalid_i` on the load edge itself is not seen; it counts as stray only if the FSM was not already in WAIT_RVALID.
- Back-to-back sustained throughput: 1 element/cycle (non-mem, `wb_ready`=1, FIFO kept non-empty).
- FIFO pointers wrap modulo DEPTH. The count ranges 0..DEPTH and never wraps.
- The push on edge E is visible as head at edge E+1; no same-edge bypass.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with random inputs → all outputs 0, no pulse; release, then idle 10 cycles → no pulse.
- **Single non-mem:** instr 0x00A00093 at counter 100, `wb_ready`=1 → one pulse; `wb_data_o.wb_data.time_start`=100, `time_end`=102.
- **Load:**
  - Stimulus: instr 0x0000A103 (mem) pushed at counter 200; `data_rvalid_i` at 205; `wb_ready` at 207.
  - Required: `mem_access_res` = 201/205, `wb_data.time_end`=207.
- **Dedup and overflow:**
  - Stimulus: `ex_data_ready` held 10 cycles on one instruction → exactly one pulse.
  - Stimulus: then 6 distinct instructions with `wb_ready`=0 and DEPTH=4.
  - Required: 5 retained (4 in FIFO + 1 in work), `overflow`=1, 5 pulses once `wb_ready` rises, in order.
- **Stray response and mid-operation reset:**
  - `data_rvalid_i` in IDLE → `trace_error`=1, no pulse.
  - Reset while in WAIT_RVALID with 2 queued → no pulse afterwards; the next accepted instruction emits normally.
- **Back-to-back:** 4 non-mem instructions on consecutive edges, `wb_ready`=1 → 4 pulses on 4 consecutive cycles, in order.
